// File: rtl/spread_scheduler.sv
// Round-robin front end that shares one registered |buy-sell| spread unit among
// NUM_REQ requesters and returns each result over a valid/ready response channel.
module spread_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int PRICE_W = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*PRICE_W-1:0] req_buy,
  input  logic [NUM_REQ*PRICE_W-1:0] req_sell,
  output logic                       calc_match_signal,
  output logic                       calc_enable_count,
  output logic [PRICE_W-1:0]         calc_buy_price,
  output logic [PRICE_W-1:0]         calc_sell_price,
  input  logic [PRICE_W-1:0]         calc_spread,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [PRICE_W-1:0]         rsp_spread,
  output logic                       rsp_cross,
  output logic                       busy,
  output logic [CNT_W-1:0]           done_count
);

  // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // a response transfers on a cycle where rsp_valid && rsp_ready. Valid never
  // depends on ready, and response fields hold steady while rsp_valid is high.

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   probe_idx;
  logic              take;
  logic [PRICE_W-1:0] sel_buy, sel_sell;

  // Search downward so the candidate closest to ptr is the last one written.
  // NUM_REQ is a power of two, so ID_W-bit addition wraps naturally.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    probe_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      probe_idx = ptr + ID_W'(k);
      if (req_valid[probe_idx]) begin
        grant_vld = 1'b1;
        grant_idx = probe_idx;
      end
    end
  end

  assign take     = !reset && (state == IDLE) && run && grant_vld;
  assign sel_buy  = req_buy[grant_idx*PRICE_W +: PRICE_W];
  assign sel_sell = req_sell[grant_idx*PRICE_W +: PRICE_W];

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESPOND;
      RESPOND: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state, so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= '0;
      calc_match_signal <= 1'b0;
      calc_enable_count <= 1'b0;
      calc_buy_price    <= '0;
      calc_sell_price   <= '0;
      rsp_valid         <= 1'b0;
      rsp_id            <= '0;
      rsp_spread        <= '0;
      rsp_cross         <= 1'b0;
      busy              <= 1'b0;
      done_count        <= '0;
    end else begin
      state             <= state_nxt;
      calc_match_signal <= (state_nxt == ISSUE);
      calc_enable_count <= (state_nxt == ISSUE);
      rsp_valid         <= (state_nxt == RESPOND);
      busy              <= (state_nxt != IDLE);
      if (take) begin
        calc_buy_price  <= sel_buy;
        calc_sell_price <= sel_sell;
        rsp_id          <= grant_idx;
        rsp_cross       <= (sel_buy >= sel_sell);
        ptr             <= grant_idx + 1'b1;
      end
      if (state == CAPTURE) rsp_spread <= calc_spread;
      if ((state == RESPOND) && rsp_ready && (done_count != {CNT_W{1'b1}}))
        done_count <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_spread_scheduler.sv
// Bench for spread_scheduler: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_spread_scheduler;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int IW = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*PW-1:0] req_buy = '0, req_sell = '0;
  logic            rsp_ready = 1'b0;

  logic [N-1:0]  req_ready, req_ready_s;
  logic          calc_match_signal, calc_enable_count, rsp_valid, rsp_cross, busy;
  logic [PW-1:0] calc_buy_price, calc_sell_price, calc_spread, rsp_spread;
  logic [IW-1:0] rsp_id;
  logic [CW-1:0] done_count;
  logic          match_s, enable_s, rsp_valid_s, rsp_cross_s, busy_s;
  logic [PW-1:0] buy_s, sell_s, calc_spread_s, rsp_spread_s;
  logic [IW-1:0] rsp_id_s;
  logic [1:0]    done_count_s;

  spread_scheduler #(.NUM_REQ(N), .PRICE_W(PW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .req_valid(req_valid), .req_ready(req_ready),
    .req_buy(req_buy), .req_sell(req_sell), .calc_match_signal(calc_match_signal),
    .calc_enable_count(calc_enable_count), .calc_buy_price(calc_buy_price),
    .calc_sell_price(calc_sell_price), .calc_spread(calc_spread), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_spread(rsp_spread), .rsp_cross(rsp_cross),
    .busy(busy), .done_count(done_count));

  // Narrow-counter instance sharing the same stimulus, to exercise saturation.
  spread_scheduler #(.NUM_REQ(N), .PRICE_W(PW), .ID_W(IW), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .run(run), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_buy(req_buy), .req_sell(req_sell), .calc_match_signal(match_s),
    .calc_enable_count(enable_s), .calc_buy_price(buy_s), .calc_sell_price(sell_s),
    .calc_spread(calc_spread_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_s), .rsp_spread(rsp_spread_s), .rsp_cross(rsp_cross_s),
    .busy(busy_s), .done_count(done_count_s));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] absd(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Spread units (environment): registered |buy-sell| on enable && match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) calc_spread <= '0;
    else if (calc_enable_count && calc_match_signal) calc_spread <= absd(calc_buy_price, calc_sell_price);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) calc_spread_s <= '0;
    else if (enable_s && match_s) calc_spread_s <= absd(buy_s, sell_s);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // age = cycles since the accepting edge (0 = no request in flight).
  int            age = 0;
  int            ptr = 0;
  int            m_id = 0;
  int            m_done = 0;
  logic [PW-1:0] m_buy = '0, m_sell = '0, m_spread = '0;
  logic          m_cross = 1'b0;
  logic [10:0]   exp_q[$];

  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_ready;
    logic [10:0] e;
    if (reset) begin
      age = 0; ptr = 0; m_id = 0; m_done = 0;
      m_buy = '0; m_sell = '0; m_spread = '0; m_cross = 1'b0;
      exp_q.delete();
    end
    g = (!reset && age == 0 && run) ? pick(ptr, req_valid) : -1;
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, age != 0);
    chk("match", calc_match_signal, age == 1);
    chk("enable", calc_enable_count, age == 1);
    chk("calc_buy", calc_buy_price, m_buy);
    chk("calc_sell", calc_sell_price, m_sell);
    chk("rsp_valid", rsp_valid, age == 3);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_spread", rsp_spread, m_spread);
    chk("rsp_cross", rsp_cross, m_cross);
    chk("done_count", done_count, (m_done > 65535) ? 65535 : m_done);
    chk("done_count_sat", done_count_s, (m_done > 3) ? 3 : m_done);
    if (!reset) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_rsp", {rsp_cross, rsp_id, rsp_spread}, e);
        end
      end
      case (age)
        0: if (g >= 0) begin
          m_buy = req_buy[g*PW +: PW];
          m_sell = req_sell[g*PW +: PW];
          m_id = g;
          m_cross = (m_buy >= m_sell);
          ptr = (g + 1) % N;
          age = 1;
          exp_q.push_back({m_cross, IW'(g), absd(m_buy, m_sell)});
        end
        1: age = 2;
        2: begin age = 3; m_spread = absd(m_buy, m_sell); end
        default: if (rsp_ready) begin age = 0; m_done++; end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [PW-1:0] b, input logic [PW-1:0] s);
    req_buy[i*PW +: PW] = b;
    req_sell[i*PW +: PW] = s;
    req_valid[i] = 1'b1;
  endtask

  // Returns at posedge+1 just after the accepting edge; seen = req_ready at grant.
  task automatic wait_grant(input string nm, output logic [N-1:0] seen);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
    seen = req_ready;
    if (req_ready == '0) chk({nm, "_grant_timeout"}, 0, 1);
    tick();
  endtask

  // Returns at the negedge where rsp_valid (and rsp_ready if need_rdy) holds; n counts negedges.
  task automatic wait_rsp(input string nm, input bit need_rdy, output int n);
    n = 1;
    @(negedge clk);
    while (!(rsp_valid && (rsp_ready || !need_rdy)) && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) chk({nm, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (busy) chk("drain_timeout", 0, 1);
    tick();
  endtask

  task automatic one_req(input string nm, input int i, input logic [PW-1:0] b, input logic [PW-1:0] s,
                         input logic [IW-1:0] e_id, input logic [PW-1:0] e_sp, input logic e_cr);
    logic [N-1:0] seen;
    int n;
    rsp_ready = 1'b1;
    set_req(i, b, s);
    wait_grant(nm, seen);
    req_valid = '0;
    wait_rsp(nm, 1'b1, n);
    chk({nm, "_id"}, rsp_id, e_id);
    chk({nm, "_spread"}, rsp_spread, e_sp);
    chk({nm, "_cross"}, rsp_cross, e_cr);
    tick();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [N-1:0] seen;
    int n;
    int ids[$];
    int cycs[$];
    logic [PW-1:0] hold_sp;
    logic [IW-1:0] hold_id;
    logic          hold_cr;

    do_reset();
    @(negedge clk);
    chk("reset_done", done_count, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    tick();

    // Single request from requester 2.
    run = 1'b1; rsp_ready = 1'b1;
    set_req(2, 8'h64, 8'h5A);
    wait_grant("t1", seen);
    req_valid = '0;
    chk("t1_ready", seen, 4'b0100);
    @(negedge clk);
    chk("t1_match_T1", calc_match_signal, 1);
    wait_rsp("t1", 1'b1, n);
    chk("t1_latency", n, 2);
    chk("t1_id", rsp_id, 2);
    chk("t1_spread", rsp_spread, 8'h0A);
    chk("t1_cross", rsp_cross, 1);
    tick();
    @(negedge clk);
    chk("t1_valid_drop", rsp_valid, 0);
    chk("t1_done", done_count, 1);
    tick();

    // All four continuously valid after reset: grants 0,1,2,3,0 every 4 cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin ids.push_back(i); cycs.push_back(c); end
    end
    tick();
    req_valid = '0;
    drain();
    chk("t2_num_grants", ids.size(), 5);
    for (int k = 0; k < ids.size() && k < 5; k++) begin
      chk("t2_grant_id", ids[k], k % 4);
      chk("t2_grant_cycle", cycs[k], 4 * k);
    end
    chk("t2_done", done_count, 5);
    chk("t2_done_narrow_sat", done_count_s, 3);

    // Spread direction and equal prices.
    one_req("t3a", 1, 8'h10, 8'h30, 2'd1, 8'h20, 1'b0);
    one_req("t3b", 3, 8'h7F, 8'h7F, 2'd3, 8'h00, 1'b1);

    // Backpressure for 10 cycles in RESPOND with other requesters pending.
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
    wait_grant("t4", seen);
    wait_rsp("t4", 1'b0, n);
    hold_sp = rsp_spread; hold_id = rsp_id; hold_cr = rsp_cross;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_spread", rsp_spread, hold_sp);
      chk("t4_hold_id", rsp_id, hold_id);
      chk("t4_hold_cross", rsp_cross, hold_cr);
      chk("t4_no_ready", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("t4_still_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("t4_completed", rsp_valid, 0);
    drain();

    // run dropped right after a grant: response still delivered, then no grants.
    do_reset();
    run = 1'b1;
    set_req(0, 8'h22, 8'h11);
    wait_grant("t5", seen);
    run = 1'b0;
    for (int i = 1; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
    wait_rsp("t5", 1'b1, n);
    chk("t5_delivered_id", rsp_id, 0);
    chk("t5_delivered_spread", rsp_spread, 8'h11);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t5_no_grant", req_ready, 0);
    end
    tick();
    run = 1'b1;
    @(negedge clk);
    chk("t5_resume", req_ready, 4'b0010);
    tick();
    drain();

    // Reset while in ISSUE: outputs clear at once, no response, pointer back to 0.
    set_req(2, 8'h40, 8'h05);
    wait_grant("t6", seen);
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_match", calc_match_signal, 0);
    chk("t6_buy", calc_buy_price, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
    wait_grant("t6b", seen);
    chk("t6_first_grant", seen, 4'b0001);
    drain();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_buy = $urandom;
      req_sell = $urandom;
      if ($urandom_range(0, 3) == 0) req_sell[7:0] = req_buy[7:0];
      rsp_ready = ($urandom_range(0, 9) < 7);
      run = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; run = 1'b1;
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
